// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg
//   Shared definitions for the reset sequencer:
//   - state_e   : FSM state encoding (WAIT_LOCK, STABILIZE, CPU_DELAY, RUN)
//   - cnt_width : width of the stability/delay counter, sized to hold the
//                 larger of the two terminal counts without wrapping.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    CPU_DELAY = 2'd2,
    RUN       = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff
//   Multi-flop synchronizer for a single asynchronous input (PLL lock,
//   push buttons, ...). Output is the last flop of the chain.
// Ports:
//   clock : destination clock, rising edge
//   reset : synchronous active-high clear of the whole chain
//   d     : asynchronous input
//   q     : synchronized output (SYNC_STAGES cycles of latency)
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Turns the PLL lock indication into ordered, registered resets for the
//   6502 system: sys_reset is released once lock has been stable for
//   LOCK_STABLE_CYCLES, cpu_reset CPU_DELAY_CYCLES after that. Any lock loss
//   or external reset re-asserts both.
// Ports:
//   clock           : PLL output clock, rising edge
//   reset           : synchronous active-high external reset
//   locked          : PLL lock, asynchronous to clock
//   sys_reset       : active-high peripheral/bus reset
//   cpu_reset       : active-high CPU core reset
//   ready           : high only while in RUN
//   lock_loss_count : saturating count of lock drops seen while in RUN
// Configuration:
//   RESET_SEQUENCER_LOSS_COUNT_EN defined   -> loss counter implemented
//   RESET_SEQUENCER_LOSS_COUNT_EN undefined -> lock_loss_count tied to 0
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 16,
  parameter int unsigned CPU_DELAY_CYCLES   = 8,
  parameter int unsigned LOSS_CNT_W         = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  locked,
  output logic                  sys_reset,
  output logic                  cpu_reset,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int unsigned CNT_W = cnt_width(LOCK_STABLE_CYCLES, CPU_DELAY_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(CPU_DELAY_CYCLES);

  logic             lock_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sys_reset_q;
  logic             cpu_reset_q;
  logic             ready_q;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clock(clock),
    .reset(reset),
    .d    (locked),
    .q    (lock_s)
  );

  // Outputs are registered alongside the state so they always reflect the
  // state being entered on this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      sys_reset_q <= 1'b1;
      cpu_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= STABILIZE;
            cnt_q   <= CNT_W'(1);
          end
        end
        STABILIZE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q     <= CPU_DELAY;
            cnt_q       <= CNT_W'(1);
            sys_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CPU_DELAY: begin
          if (!lock_s) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sys_reset_q <= 1'b1;
          end else if (cnt_q == DELAY_LAST) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            cpu_reset_q <= 1'b0;
            ready_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q     <= WAIT_LOCK;
            sys_reset_q <= 1'b1;
            cpu_reset_q <= 1'b1;
            ready_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= WAIT_LOCK;
          cnt_q       <= '0;
          sys_reset_q <= 1'b1;
          cpu_reset_q <= 1'b1;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign sys_reset = sys_reset_q;
  assign cpu_reset = cpu_reset_q;
  assign ready     = ready_q;

`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      loss_q <= '0;
    end else if ((state_q == RUN) && !lock_s && (loss_q != '1)) begin
      loss_q <= loss_q + LOSS_CNT_W'(1);
    end
  end

  assign lock_loss_count = loss_q;
`else
  assign lock_loss_count = '0;
`endif

endmodule
